// File: rtl/prgm_reader_if.sv
// ============================================================================
// prgm_reader_if : control, program-memory and output handshake bundle
//                  for the program memory read-back engine.
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface prgm_reader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] start_adrs;
  logic [ADDR_W:0]   length;
  logic              abort;
  logic [ADDR_W-1:0] mem_adrs;
  logic              mem_req;
  logic [DATA_W-1:0] mem_out;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, start_adrs, length, abort, mem_out, out_ready,
    output mem_adrs, mem_req, out_data, out_valid, busy, done
  );

  modport slave (
    output start, start_adrs, length, abort, mem_out, out_ready,
    input  mem_adrs, mem_req, out_data, out_valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/prgm_reader.sv
// ============================================================================
// prgm_reader : walks program memory from a start address, holds each address
//               for a settle time, then presents the word on valid/ready.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module prgm_reader #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int READ_WAIT = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  prgm_reader_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic [3:0]      LAST_WAIT = 4'(READ_WAIT - 1);
  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] REM_ONE   = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] adrs_q, adrs_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   len_clamped;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    rem_d       = rem_q;
    adrs_d      = adrs_q;
    req_d       = req_q;
    data_d      = data_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    len_clamped = (bus.length > DEPTH) ? DEPTH : bus.length;

    case (state_q)
      IDLE: begin
        // start wins over a simultaneous abort; abort is meaningless here
        if (bus.start) begin
          rem_d = len_clamped;
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = WAIT;
            adrs_d     = bus.start_adrs;
            req_d      = 1'b1;
            wait_cnt_d = '0;
          end
        end
      end
      WAIT: begin
        if (bus.abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          req_d   = 1'b0;
        end else if (wait_cnt_q == LAST_WAIT) begin
          data_d  = bus.mem_out;
          valid_d = 1'b1;
          state_d = PRESENT;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      PRESENT: begin
        // abort takes priority over a same-edge handshake
        if (bus.abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          req_d   = 1'b0;
        end else if (bus.out_ready) begin
          valid_d = 1'b0;
          rem_d   = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = IDLE;
            req_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            adrs_d     = adrs_q + 1'b1;
            wait_cnt_d = '0;
            state_d    = WAIT;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      rem_q      <= '0;
      adrs_q     <= '0;
      req_q      <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rem_q      <= rem_d;
      adrs_q     <= adrs_d;
      req_q      <= req_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  assign bus.mem_adrs  = adrs_q;
  assign bus.mem_req   = req_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_prgm_reader.sv
// ============================================================================
// tb_prgm_reader : directed self-checking bench for prgm_reader.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_prgm_reader;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [7:0] mem [64];

  int got_data[$];
  int got_adrs[$];
  int got_cyc[$];
  int done_cnt;
  int done_cyc;
  int overlap;

  prgm_reader_if #(.ADDR_W(6), .DATA_W(8)) bus ();

  prgm_reader #(.ADDR_W(6), .DATA_W(8), .READ_WAIT(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  assign bus.mem_out = mem[bus.mem_adrs];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int sa, input int len);
    bus.start      = 1'b1;
    bus.start_adrs = 6'(sa);
    bus.length     = 7'(len);
    tick();
    bus.start      = 1'b0;
  endtask

  // records handshakes and done pulses; returns at the done cycle or budget
  task automatic collect(input int max_cyc);
    got_data.delete();
    got_adrs.delete();
    got_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    overlap  = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(int'(bus.out_data));
        got_adrs.push_back(int'(bus.mem_adrs));
        got_cyc.push_back(c);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
        if (bus.out_valid) overlap++;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    total++;
    if (bus.mem_adrs !== 6'd0 || bus.mem_req !== 1'b0 || bus.out_data !== 8'd0 ||
        bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got adrs=%0d req=%b data=%h valid=%b busy=%b done=%b, want all 0",
               bus.mem_adrs, bus.mem_req, bus.out_data, bus.out_valid, bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    int exp_d [3];
    int exp_c [3];
    exp_d = '{'h11, 'h22, 'h33};
    exp_c = '{5, 11, 17};
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    bus.out_ready = 1'b1;
    do_start(0, 3);
    total++;
    if (bus.busy !== 1'b1 || bus.mem_req !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_enter_wait: got busy=%b req=%b valid=%b, want 1 1 0",
               bus.busy, bus.mem_req, bus.out_valid);
    end
    collect(40);
    total++;
    if (got_data.size() != 3) begin
      bad++;
      $display("FAIL basic_count: got %0d words, want 3", got_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got_data[i] != exp_d[i] || got_cyc[i] != exp_c[i]) begin
          bad++;
          $display("FAIL basic_word%0d: got data=%h cyc=%0d, want data=%h cyc=%0d",
                   i, got_data[i], got_cyc[i], exp_d[i], exp_c[i]);
        end
      end
    end
    total++;
    if (done_cnt != 1 || done_cyc != 18 || bus.busy !== 1'b0 || overlap != 0) begin
      bad++;
      $display("FAIL basic_done: got cnt=%0d cyc=%0d busy=%b overlap=%0d, want 1 18 0 0",
               done_cnt, done_cyc, bus.busy, overlap);
    end
    tick();
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_width: got done=%b one cycle later, want 0", bus.done);
    end
  endtask

  task automatic test_wrap();
    int exp_a [4];
    exp_a = '{62, 63, 0, 1};
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    bus.out_ready = 1'b1;
    do_start(62, 4);
    collect(60);
    total++;
    if (got_data.size() != 4 || done_cnt != 1) begin
      bad++;
      $display("FAIL wrap_count: got %0d words done=%0d, want 4 words done=1",
               got_data.size(), done_cnt);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_adrs[i] != exp_a[i] || got_data[i] != exp_a[i]) begin
          bad++;
          $display("FAIL wrap_word%0d: got adrs=%0d data=%h, want adrs=%0d data=%h",
                   i, got_adrs[i], got_data[i], exp_a[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int hold_d;
    int hold_a;
    int changed;
    int waited;
    bus.out_ready = 1'b0;
    do_start(5, 2);
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_valid_timeout: got valid=%b, want 1 within 20 cycles", bus.out_valid);
    end
    hold_d  = int'(bus.out_data);
    hold_a  = int'(bus.mem_adrs);
    changed = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid !== 1'b1 || int'(bus.out_data) != hold_d || int'(bus.mem_adrs) != hold_a)
        changed++;
    end
    total++;
    if (changed != 0 || hold_d != 5 || hold_a != 5) begin
      bad++;
      $display("FAIL bp_hold: got %0d unstable cycles data=%h adrs=%0d, want 0 unstable data=05 adrs=5",
               changed, hold_d, hold_a);
    end
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.mem_adrs !== 6'd6 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL bp_accept: got valid=%b adrs=%0d busy=%b, want 0 6 1",
               bus.out_valid, bus.mem_adrs, bus.busy);
    end
    collect(30);
    total++;
    if (got_data.size() != 1 || got_data[0] != 6 || done_cnt != 1) begin
      bad++;
      $display("FAIL bp_rest: got %0d words first=%0d done=%0d, want 1 word 6 done=1",
               got_data.size(), (got_data.size() > 0) ? got_data[0] : -1, done_cnt);
    end
  endtask

  task automatic test_length_bounds();
    int req_seen;
    int bad_words;
    bus.out_ready = 1'b1;
    do_start(4, 0);
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL len0_done: got done=%b busy=%b req=%b, want 1 0 0",
               bus.done, bus.busy, bus.mem_req);
    end
    req_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.mem_req || bus.out_valid || bus.done) req_seen++;
    end
    total++;
    if (req_seen != 0) begin
      bad++;
      $display("FAIL len0_quiet: got %0d active cycles, want 0", req_seen);
    end
    do_start(10, 100);
    collect(450);
    total++;
    if (got_data.size() != 64 || done_cnt != 1 || overlap != 0) begin
      bad++;
      $display("FAIL len100_count: got %0d words done=%0d overlap=%0d, want 64 1 0",
               got_data.size(), done_cnt, overlap);
    end else begin
      bad_words = 0;
      for (int i = 0; i < 64; i++)
        if (got_adrs[i] != ((10 + i) % 64) || got_data[i] != got_adrs[i]) bad_words++;
      total++;
      if (bad_words != 0 || got_adrs[63] != 9) begin
        bad++;
        $display("FAIL len100_wrap: got %0d wrong words last adrs=%0d, want 0 wrong last adrs=9",
                 bad_words, got_adrs[63]);
      end
    end
  endtask

  task automatic test_start_abort();
    bus.out_ready = 1'b1;
    do_start(20, 2);
    tick();
    do_start(40, 5);
    collect(40);
    total++;
    if (got_data.size() != 2 || got_data[0] != 20 || got_data[1] != 21 || done_cnt != 1) begin
      bad++;
      $display("FAIL restart_ignored: got %0d words done=%0d, want 2 words 20,21 done=1",
               got_data.size(), done_cnt);
    end
    tick();
    do_start(30, 3);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.done !== 1'b0 || bus.out_data !== 8'h15) begin
      bad++;
      $display("FAIL abort_idle: got busy=%b req=%b valid=%b done=%b data=%h, want 0 0 0 0 15",
               bus.busy, bus.mem_req, bus.out_valid, bus.done, bus.out_data);
    end
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: got done=%b busy=%b, want 0 0", bus.done, bus.busy);
    end
    do_start(7, 1);
    collect(20);
    total++;
    if (got_data.size() != 1 || got_data[0] != 7 || done_cnt != 1) begin
      bad++;
      $display("FAIL after_abort: got %0d words done=%0d, want 1 word 7 done=1",
               got_data.size(), done_cnt);
    end
  endtask

  task automatic test_async_reset();
    int waited;
    bus.out_ready = 1'b0;
    do_start(3, 2);
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h03) begin
      bad++;
      $display("FAIL arst_present: got valid=%b data=%h, want 1 03", bus.out_valid, bus.out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.mem_adrs !== 6'd0 || bus.mem_req !== 1'b0 || bus.out_data !== 8'd0 ||
        bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL arst_outputs: got adrs=%0d req=%b data=%h valid=%b busy=%b done=%b, want all 0",
               bus.mem_adrs, bus.mem_req, bus.out_data, bus.out_valid, bus.busy, bus.done);
    end
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    do_start(9, 1);
    collect(20);
    total++;
    if (got_data.size() != 1 || got_data[0] != 9 || done_cnt != 1) begin
      bad++;
      $display("FAIL arst_recover: got %0d words done=%0d, want 1 word 9 done=1",
               got_data.size(), done_cnt);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.start_adrs = '0;
    bus.length     = '0;
    bus.abort      = 1'b0;
    bus.out_ready  = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    #1;
    test_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_basic();
    tick();
    test_wrap();
    tick();
    test_backpressure();
    tick();
    test_length_bounds();
    tick();
    test_start_abort();
    tick();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
